// File: rtl/vpu_lane_wb_pkg.sv
// Shared VPU types for the lane writeback stage: element width, writeback tag,
// entry state and the SEW-to-byte-enable helper.
package vpu_lane_wb_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } VSEW_e;

    localparam int VPU_VREG_W   = 5;
    localparam int VPU_WB_IDX_W = 5;

    typedef struct packed {
        logic [VPU_VREG_W-1:0]   vd;
        logic [VPU_WB_IDX_W-1:0] idx;
        VSEW_e                   vsew;
    } vpu_wb_tag_t;

    typedef enum logic [1:0] {
        WB_EMPTY = 2'd0,
        WB_PEND  = 2'd1,
        WB_DONE  = 2'd2
    } vpu_wb_state_e;

    function automatic logic [7:0] vsew_to_be(input VSEW_e vsew);
        logic [7:0] be;
        be = 8'h00;
        case (vsew)
            SEW8:    be = 8'h01;
            SEW16:   be = 8'h03;
            SEW32:   be = 8'h0F;
            SEW64:   be = 8'hFF;
            default: be = 8'h00;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/vpu_lane_wb_queue.sv
// In-order writeback queue: per-slot tag/result storage with allocate, result
// and retire pointers plus an occupancy count.
module vpu_wb_queue
    import vpu_lane_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_flush,
    input  logic          i_alloc,
    input  vpu_wb_tag_t   i_allocTag,
    input  logic          i_resWr,
    input  logic [63:0]   i_resData,
    input  logic          i_resEn,
    input  logic          i_retire,
    output logic          o_full,
    output logic          o_empty,
    output vpu_wb_state_e o_headState,
    output vpu_wb_tag_t   o_headTag,
    output logic [63:0]   o_headData,
    output logic          o_headEn,
    output vpu_wb_state_e o_resState
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    vpu_wb_state_e r_state [DEPTH];
    vpu_wb_tag_t   r_tag   [DEPTH];
    logic [63:0]   r_data  [DEPTH];
    logic          r_en    [DEPTH];

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_resPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    // Retire is applied last so that a same-slot result (bypass retire) leaves the slot EMPTY.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= WB_EMPTY;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
                r_en[i]    <= 1'b0;
            end
            r_wrPtr  <= '0;
            r_resPtr <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= WB_EMPTY;
            end
            r_wrPtr  <= '0;
            r_resPtr <= '0;
            r_rdPtr  <= '0;
            r_count  <= '0;
        end else begin
            if (i_alloc) begin
                r_state[r_wrPtr] <= WB_PEND;
                r_tag[r_wrPtr]   <= i_allocTag;
                r_wrPtr          <= r_wrPtr + 1'b1;
            end
            if (i_resWr) begin
                r_state[r_resPtr] <= WB_DONE;
                r_data[r_resPtr]  <= i_resData;
                r_en[r_resPtr]    <= i_resEn;
                r_resPtr          <= r_resPtr + 1'b1;
            end
            if (i_retire) begin
                r_state[r_rdPtr] <= WB_EMPTY;
                r_rdPtr          <= r_rdPtr + 1'b1;
            end
            case ({i_alloc, i_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_empty     = (r_count == '0);
    assign o_headState = r_state[r_rdPtr];
    assign o_headTag   = r_tag[r_rdPtr];
    assign o_headData  = r_data[r_rdPtr];
    assign o_headEn    = r_en[r_rdPtr];
    assign o_resState  = r_state[r_resPtr];

endmodule

// File: rtl/vpu_lane_wb.sv
// VPU lane writeback stage: pairs in-order lane results with issued tags and
// drives VRF writes. Optional zero-latency head bypass: VPU_WB_BYPASS_EN.
module vpu_lane_wb
    import vpu_lane_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             issue_valid_i,
    output logic             issue_ready_o,
    input  logic [4:0]       issue_vd_i,
    input  logic [IDX_W-1:0] issue_idx_i,
    input  VSEW_e            issue_vsew_i,
    input  logic             result_valid_i,
    input  logic             result_en_i,
    input  logic [63:0]      result_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [4:0]       wb_vd_o,
    output logic [IDX_W-1:0] wb_idx_o,
    output logic [63:0]      wb_data_o,
    output logic [7:0]       wb_be_o,
    output logic             idle_o,
    output logic             err_o
);

    logic          w_full;
    logic          w_empty;
    logic          w_issueFire;
    logic          w_resPend;
    logic          w_resAccept;
    logic          w_headWrite;
    logic          w_headDrop;
    logic          w_bypass;
    logic          w_retire;
    logic          w_headEn;
    logic [63:0]   w_headData;
    vpu_wb_tag_t   w_issueTag;
    vpu_wb_tag_t   w_headTag;
    vpu_wb_state_e w_headState;
    vpu_wb_state_e w_resState;
    logic          r_err;

    always_comb begin
        w_issueTag      = '0;
        w_issueTag.vd   = issue_vd_i;
        w_issueTag.idx  = VPU_WB_IDX_W'(issue_idx_i);
        w_issueTag.vsew = issue_vsew_i;
    end

    assign issue_ready_o = ~w_full;
    assign idle_o        = w_empty;
    assign err_o         = r_err;

    assign w_issueFire = issue_valid_i & ~w_full & ~flush_i;
    assign w_resPend   = (w_resState == WB_PEND);
    assign w_resAccept = result_valid_i & w_resPend & ~flush_i;
    assign w_headWrite = (w_headState == WB_DONE) & w_headEn;
    assign w_headDrop  = (w_headState == WB_DONE) & ~w_headEn;

    // A PEND head is necessarily the oldest pending entry, so it is the result target.
`ifdef VPU_WB_BYPASS_EN
    assign w_bypass = result_valid_i & result_en_i & (w_headState == WB_PEND);
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        wb_valid_o = w_headWrite | w_bypass;
        wb_vd_o    = '0;
        wb_idx_o   = '0;
        wb_data_o  = '0;
        wb_be_o    = '0;
        if (w_headWrite || w_bypass) begin
            wb_vd_o   = w_headTag.vd;
            wb_idx_o  = IDX_W'(w_headTag.idx);
            wb_data_o = w_headWrite ? w_headData : result_i;
            wb_be_o   = vsew_to_be(w_headTag.vsew);
        end
    end

    assign w_retire = ~flush_i & (w_headDrop | (wb_valid_o & wb_ready_i));

    // Sticky until reset; a flush deliberately leaves it set.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (result_valid_i && !w_resPend) begin
            r_err <= 1'b1;
        end
    end

    vpu_wb_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk       (clk_i),
        .i_rst_n     (rst_i),
        .i_flush     (flush_i),
        .i_alloc     (w_issueFire),
        .i_allocTag  (w_issueTag),
        .i_resWr     (w_resAccept),
        .i_resData   (result_i),
        .i_resEn     (result_en_i),
        .i_retire    (w_retire),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_headState (w_headState),
        .o_headTag   (w_headTag),
        .o_headData  (w_headData),
        .o_headEn    (w_headEn),
        .o_resState  (w_resState)
    );

endmodule

// File: tb/tb_vpu_lane_wb.sv
// Scoreboard bench for vpu_lane_wb: tags queued at issue, expected writes queued
// at result time and compared when the VRF handshake completes.
module tb_vpu_lane_wb;
    import vpu_lane_wb_pkg::*;

    localparam int DEPTH = 4;
    localparam int IDX_W = 5;

    logic             clk_i;
    logic             rst_i;
    logic             flush_i;
    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [4:0]       issue_vd_i;
    logic [IDX_W-1:0] issue_idx_i;
    VSEW_e            issue_vsew_i;
    logic             result_valid_i;
    logic             result_en_i;
    logic [63:0]      result_i;
    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [4:0]       wb_vd_o;
    logic [IDX_W-1:0] wb_idx_o;
    logic [63:0]      wb_data_o;
    logic [7:0]       wb_be_o;
    logic             idle_o;
    logic             err_o;

    vpu_lane_wb #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_ready_o  (issue_ready_o),
        .issue_vd_i     (issue_vd_i),
        .issue_idx_i    (issue_idx_i),
        .issue_vsew_i   (issue_vsew_i),
        .result_valid_i (result_valid_i),
        .result_en_i    (result_en_i),
        .result_i       (result_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_vd_o        (wb_vd_o),
        .wb_idx_o       (wb_idx_o),
        .wb_data_o      (wb_data_o),
        .wb_be_o        (wb_be_o),
        .idle_o         (idle_o),
        .err_o          (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]       vd;
        logic [IDX_W-1:0] idx;
        VSEW_e            sew;
    } tagT;

    typedef struct {
        logic [4:0]       vd;
        logic [IDX_W-1:0] idx;
        logic [63:0]      data;
        logic [7:0]       be;
    } expT;

    tagT  tagQ[$];
    expT  expQ[$];
    expT  monE;
    int   checkCount = 0;
    int   passCount  = 0;
    logic expErr     = 1'b0;

    localparam logic [63:0] BP0 = 64'hA5A5_0000_1111_2222;
    localparam logic [63:0] BP1 = 64'h5A5A_3333_4444_5555;
    localparam logic [63:0] BP2 = 64'hDEAD_BEEF_CAFE_F00D;

    function automatic logic [7:0] beOf(input VSEW_e s);
        case (s)
            SEW8:    return 8'b0000_0001;
            SEW16:   return 8'b0000_0011;
            SEW32:   return 8'b0000_1111;
            default: return 8'b1111_1111;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Drives one cycle of inputs and updates the model; the result is modelled before the issue.
    task automatic applyStimulus(input logic doIssue, input logic [4:0] vd, input logic [IDX_W-1:0] idx,
                                 input VSEW_e sew, input logic doRes, input logic en, input logic [63:0] data);
        tagT t;
        if (doRes) begin
            result_valid_i = 1'b1;
            result_en_i    = en;
            result_i       = data;
            if (tagQ.size() == 0) begin
                expErr = 1'b1;
            end else begin
                t = tagQ.pop_front();
                if (en) expQ.push_back('{t.vd, t.idx, data, beOf(t.sew)});
            end
        end
        if (doIssue) begin
            issue_valid_i = 1'b1;
            issue_vd_i    = vd;
            issue_idx_i   = idx;
            issue_vsew_i  = sew;
            tagQ.push_back('{vd, idx, sew});
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        issue_valid_i  = 1'b0;
        result_valid_i = 1'b0;
        result_en_i    = 1'b0;
        flush_i        = 1'b0;
    endtask

    task automatic issueOnly(input logic [4:0] vd, input logic [IDX_W-1:0] idx, input VSEW_e sew);
        applyStimulus(1'b1, vd, idx, sew, 1'b0, 1'b0, 64'd0);
        tick();
    endtask

    task automatic resultOnly(input logic en, input logic [63:0] data);
        applyStimulus(1'b0, 5'd0, '0, SEW8, 1'b1, en, data);
        tick();
    endtask

    always @(negedge clk_i) begin
        if (rst_i && wb_valid_o && wb_ready_i) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWrite", 64'(wb_valid_o), 64'd0);
            end else begin
                monE = expQ.pop_front();
                checkOutput("wbVd",   64'(wb_vd_o),  64'(monE.vd));
                checkOutput("wbIdx",  64'(wb_idx_o), 64'(monE.idx));
                checkOutput("wbData", wb_data_o,     monE.data);
                checkOutput("wbBe",   64'(wb_be_o),  64'(monE.be));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_i          = 1'b1;
        flush_i        = 1'b0;
        issue_valid_i  = 1'b0;
        issue_vd_i     = '0;
        issue_idx_i    = '0;
        issue_vsew_i   = SEW8;
        result_valid_i = 1'b0;
        result_en_i    = 1'b0;
        result_i       = '0;
        wb_ready_i     = 1'b1;
        #1 rst_i = 1'b0;
        #1;
        checkOutput("rstWbValid",    64'(wb_valid_o),    64'd0);
        checkOutput("rstIssueReady", 64'(issue_ready_o), 64'd1);
        checkOutput("rstIdle",       64'(idle_o),        64'd1);
        checkOutput("rstErr",        64'(err_o),         64'd0);
        checkOutput("rstData",       wb_data_o,          64'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b1;

        // Single op with one-cycle latency (zero with the bypass build).
        issueOnly(5'd3, 5'd2, SEW32);
        applyStimulus(1'b0, 5'd0, '0, SEW8, 1'b1, 1'b1, 64'h1122_3344_5566_7788);
`ifdef VPU_WB_BYPASS_EN
        #1;
        checkOutput("singleLatency", 64'(wb_valid_o), 64'd1);
        tick();
`else
        tick();
        checkOutput("singleLatency", 64'(wb_valid_o), 64'd1);
`endif
        tick();
        checkOutput("singleIdle", 64'(idle_o), 64'd1);

        // Fill the queue; a fifth issue must be refused.
        for (int i = 0; i < DEPTH; i++) issueOnly(5'(4 + i), 5'(i), SEW64);
        checkOutput("fillReady", 64'(issue_ready_o), 64'd0);
        checkOutput("fillIdle",  64'(idle_o),        64'd0);
        issue_valid_i = 1'b1;
        issue_vd_i    = 5'd9;
        issue_idx_i   = 5'd31;
        issue_vsew_i  = SEW8;
        tick();
        checkOutput("fillStillFull", 64'(issue_ready_o), 64'd0);
        for (int i = 0; i < DEPTH; i++) resultOnly(1'b1, 64'h1000 + 64'(i));
        tick();
        tick();
        checkOutput("fillDrainIdle",  64'(idle_o),        64'd1);
        checkOutput("fillDrainReady", 64'(issue_ready_o), 64'd1);
        checkOutput("fillDrainQ",     64'(expQ.size()),   64'd0);

        // Backpressure: three completed results held, then released.
        wb_ready_i = 1'b0;
        issueOnly(5'd10, 5'd5, SEW16);
        issueOnly(5'd11, 5'd6, SEW32);
        issueOnly(5'd12, 5'd7, SEW8);
        resultOnly(1'b1, BP0);
        resultOnly(1'b1, BP1);
        resultOnly(1'b1, BP2);
        for (int k = 0; k < 5; k++) begin
            checkOutput("bpValid", 64'(wb_valid_o), 64'd1);
            checkOutput("bpVd",    64'(wb_vd_o),    64'd10);
            checkOutput("bpData",  wb_data_o,       BP0);
            checkOutput("bpBe",    64'(wb_be_o),    64'h03);
            tick();
        end
        wb_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("bpConsec", 64'(wb_valid_o), 64'd1);
            tick();
        end
        checkOutput("bpIdle", 64'(idle_o), 64'd1);

        // Masked element A followed by SEW8 element B.
        issueOnly(5'd13, 5'd1, SEW64);
        issueOnly(5'd14, 5'd3, SEW8);
        resultOnly(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        checkOutput("maskNoWrite", 64'(wb_valid_o), 64'd0);
        resultOnly(1'b1, 64'h0000_0000_0000_00AB);
        checkOutput("maskBValid", 64'(wb_valid_o), 64'd1);
        checkOutput("maskBBe",    64'(wb_be_o),    64'h01);
        tick();
        checkOutput("maskIdle", 64'(idle_o), 64'd1);

        // Flush with two pending entries; their late results are spurious.
        issueOnly(5'd15, 5'd8, SEW32);
        issueOnly(5'd16, 5'd9, SEW32);
        flush_i = 1'b1;
        tagQ.delete();
        expQ.delete();
        tick();
        checkOutput("flushIdle",    64'(idle_o),        64'd1);
        checkOutput("flushReady",   64'(issue_ready_o), 64'd1);
        checkOutput("flushWbValid", 64'(wb_valid_o),    64'd0);
        checkOutput("flushErr",     64'(err_o),         64'(expErr));
        resultOnly(1'b1, 64'h1234);
        checkOutput("spuriousErr", 64'(err_o), 64'(expErr));
        resultOnly(1'b1, 64'h5678);
        checkOutput("spuriousNoWrite", 64'(wb_valid_o), 64'd0);
        flush_i = 1'b1;
        tick();
        checkOutput("errSticky", 64'(err_o), 64'(expErr));

        // Reset with three DONE entries held by backpressure.
        wb_ready_i = 1'b0;
        issueOnly(5'd17, 5'd10, SEW8);
        issueOnly(5'd18, 5'd11, SEW16);
        issueOnly(5'd19, 5'd12, SEW64);
        resultOnly(1'b1, 64'h77);
        resultOnly(1'b1, 64'h88);
        resultOnly(1'b1, 64'h99);
        checkOutput("preRstValid", 64'(wb_valid_o), 64'd1);
        rst_i = 1'b0;
        tagQ.delete();
        expQ.delete();
        expErr = 1'b0;
        #1;
        checkOutput("midRstValid", 64'(wb_valid_o),    64'd0);
        checkOutput("midRstVd",    64'(wb_vd_o),       64'd0);
        checkOutput("midRstIdx",   64'(wb_idx_o),      64'd0);
        checkOutput("midRstData",  wb_data_o,          64'd0);
        checkOutput("midRstBe",    64'(wb_be_o),       64'd0);
        checkOutput("midRstReady", 64'(issue_ready_o), 64'd1);
        checkOutput("midRstIdle",  64'(idle_o),        64'd1);
        checkOutput("midRstErr",   64'(err_o),         64'd0);
        tick();
        tick();
        rst_i      = 1'b1;
        wb_ready_i = 1'b1;
        issueOnly(5'd21, 5'd17, SEW64);
        resultOnly(1'b1, 64'h0123_4567_89AB_CDEF);
        tick();
        tick();
        checkOutput("postRstIdle", 64'(idle_o),       64'd1);
        checkOutput("endExpQ",     64'(expQ.size()),  64'd0);
        checkOutput("endTagQ",     64'(tagQ.size()),  64'd0);
        checkOutput("endErr",      64'(err_o),        64'(expErr));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
